// File: rtl/tdm_demux_if.sv
// Slot-serial input and parallel-frame output bundle of the TDM demultiplexer.
interface tdm_demux_if #(
  parameter int CH = 16,
  parameter int W  = 1
);
  localparam int SW = $clog2(CH);

  logic [W-1:0]    din;
  logic            din_valid;
  logic            sync;
  logic [CH*W-1:0] dout;
  logic            dout_valid;
  logic [SW-1:0]   slot;
  logic            locked;
  logic            sync_err;

  modport master (
    output din, din_valid, sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output dout, dout_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: acquires frame lock on a slot-serial stream, flywheels over missed
// syncs and presents each completed locked frame in parallel, 1 clk after its last beat.
module tdm_demux #(
  parameter int CH          = 16,
  parameter int W           = 1,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave bus
);
  localparam int SW = $clog2(CH);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(MISS_FRAMES + 1);
  localparam logic [SW-1:0] LAST = SW'(CH - 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [GW-1:0]       good_q, good_d, good_inc;
  logic [MW-1:0]       miss_q, miss_d, miss_inc;
  logic [(CH-1)*W-1:0] shadow_q;
  logic [CH*W-1:0]     dout_q;
  logic                dout_valid_q, sync_err_q;
  logic                cap, emit, err;
  logic [SW-1:0]       cap_idx;
  logic                beat, exp_beat, lock_hit, miss_hit;

  assign beat     = bus.din_valid;
  assign exp_beat = beat && (slot_q == '0);
  assign good_inc = good_q + GW'(1);
  assign miss_inc = miss_q + MW'(1);
  assign lock_hit = (good_inc == GW'(LOCK_FRAMES));
  assign miss_hit = (miss_inc == MW'(MISS_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (beat && bus.sync) state_d = CONFIRM;
      CONFIRM: if (exp_beat) state_d = !bus.sync ? HUNT : (lock_hit ? LOCKED : CONFIRM);
      LOCKED:  if (exp_beat && !bus.sync && miss_hit) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    slot_d  = slot_q;
    good_d  = good_q;
    miss_d  = miss_q;
    cap     = 1'b0;
    cap_idx = slot_q;
    emit    = 1'b0;
    err     = 1'b0;
    if (beat) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            cap     = 1'b1;
            cap_idx = '0;
            slot_d  = SW'(1);
            good_d  = '0;
          end
        end
        CONFIRM: begin
          // A sync off slot 0 is treated as the new frame start and restarts the count.
          if (bus.sync && slot_q != '0) begin
            cap     = 1'b1;
            cap_idx = '0;
            slot_d  = SW'(1);
            good_d  = '0;
          end else if (slot_q == '0 && !bus.sync) begin
            slot_d = '0;
          end else begin
            cap    = 1'b1;
            slot_d = slot_q + SW'(1);
            if (slot_q == '0) begin
              good_d = good_inc;
              if (lock_hit) miss_d = '0;
            end
          end
        end
        LOCKED: begin
          if (slot_q == '0 && !bus.sync && miss_hit) begin
            slot_d = '0;
            miss_d = '0;
          end else begin
            cap    = 1'b1;
            slot_d = slot_q + SW'(1);
            if (slot_q == '0) miss_d = bus.sync ? '0 : miss_inc;
            err    = bus.sync && (slot_q != '0);
            emit   = (slot_q == LAST);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      dout_valid_q <= emit;
      sync_err_q   <= err;
      if (emit) dout_q <= {bus.din, shadow_q};
      // The last slot bypasses the shadow and is taken straight from din.
      for (int i = 0; i < CH - 1; i++) begin
        if (cap && cap_idx == SW'(i)) shadow_q[i*W +: W] <= bus.din;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with CH=16, W=1, LOCK_FRAMES=2, MISS_FRAMES=2.
module tb_tdm_demux;
  localparam int CH = 16;
  localparam int W  = 1;

  logic clk;
  logic rst_n;
  tdm_demux_if #(.CH(CH), .W(W)) bus ();

  tdm_demux #(.CH(CH), .W(W), .LOCK_FRAMES(2), .MISS_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pulses = 0;
  int errs   = 0;
  int p0;
  bit gaps   = 0;
  logic [15:0] capq[$];
  logic [15:0] exp5[4] = '{16'hA5C3, 16'h1357, 16'hFFFF, 16'h8001};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      pulses++;
      capq.push_back(bus.dout);
    end
    if (bus.sync_err) errs++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic beat(input logic d, input logic s);
    if (gaps) begin
      while ($urandom_range(9) < 4) begin
        bus.din_valid = 1'b0;
        bus.din       = 1'($urandom_range(1));
        bus.sync      = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
    end
    bus.din       = d;
    bus.sync      = s;
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  task automatic send_range(input logic [15:0] pat, input logic [15:0] smask,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++) beat(pat[i], smask[i]);
  endtask

  task automatic idle();
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.sync = 1'b0;

    // 1: reset holds everything at zero regardless of inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.din = 1'($urandom_range(1)); bus.sync = 1'($urandom_range(1)); bus.din_valid = 1'b1;
    end
    #1;
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_slot", bus.slot, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_sync_err", bus.sync_err, 0);
    @(negedge clk);
    bus.din_valid = 1'b0; bus.sync = 1'b0;
    rst_n = 1'b1;
    idle();
    check("rel_slot", bus.slot, 0);
    check("rel_locked", bus.locked, 0);

    // 2: acquisition
    send_range(16'hA5C3, 16'h0001, 0, 0);
    check("acq_slot", bus.slot, 1);
    send_range(16'hA5C3, 16'h0001, 1, 15);
    send_range(16'hA5C3, 16'h0001, 0, 15);
    check("pre_lock", bus.locked, 0);
    send_range(16'hA5C3, 16'h0001, 0, 0);
    check("lock_b32", bus.locked, 1);
    check("no_early_pulse", pulses, 0);
    send_range(16'hA5C3, 16'h0001, 1, 15);
    check("first_valid", bus.dout_valid, 1);
    check("first_dout", bus.dout, 16'hA5C3);
    send_range(16'h1234, 16'h0001, 0, 15);
    check("second_dout", bus.dout, 16'h1234);
    check("slot_wrap", bus.slot, 0);
    idle();
    check("valid_pulse_end", bus.dout_valid, 0);
    check("dout_hold", bus.dout, 16'h1234);
    check("pulses_t2", pulses, 2);

    // 3: flywheel over one miss, drop on two
    send_range(16'h0F0F, 16'h0000, 0, 15);
    check("miss1_locked", bus.locked, 1);
    check("miss1_valid", bus.dout_valid, 1);
    check("miss1_dout", bus.dout, 16'h0F0F);
    send_range(16'h1111, 16'h0001, 0, 15);
    check("resync_dout", bus.dout, 16'h1111);
    send_range(16'hBEEF, 16'h0000, 0, 15);
    check("miss_a_dout", bus.dout, 16'hBEEF);
    check("miss_a_locked", bus.locked, 1);
    send_range(16'hFFFF, 16'h0000, 0, 0);
    check("miss2_unlock", bus.locked, 0);
    check("miss2_slot", bus.slot, 0);
    send_range(16'hFFFF, 16'h0000, 1, 15);
    check("hunt_hold", bus.slot, 0);
    idle();
    check("pulses_t3", pulses, 5);
    send_range(16'h5A5A, 16'h0001, 0, 15);
    send_range(16'h5A5A, 16'h0001, 0, 15);
    idle();
    check("no_pulse_confirm", pulses, 5);
    send_range(16'h5A5A, 16'h0001, 0, 15);
    check("relock", bus.locked, 1);
    check("relock_dout", bus.dout, 16'h5A5A);
    idle();
    check("pulses_relock", pulses, 6);

    // 4: stray sync while locked
    send_range(16'h3C96, 16'h0021, 0, 5);
    check("sync_err_on", bus.sync_err, 1);
    send_range(16'h3C96, 16'h0021, 6, 6);
    check("sync_err_off", bus.sync_err, 0);
    send_range(16'h3C96, 16'h0021, 7, 15);
    check("err_frame_valid", bus.dout_valid, 1);
    check("err_frame_dout", bus.dout, 16'h3C96);
    check("err_locked", bus.locked, 1);
    idle();
    check("err_count", errs, 1);

    // 5: random valid gaps
    capq.delete();
    p0 = pulses;
    gaps = 1;
    for (int f = 0; f < 4; f++) send_range(exp5[f], 16'h0001, 0, 15);
    gaps = 0;
    idle();
    check("gap_pulses", pulses - p0, 4);
    check("gap_qsize", capq.size(), 4);
    for (int f = 0; f < 4 && f < capq.size(); f++)
      check($sformatf("gap_dout%0d", f), capq[f], exp5[f]);
    check("gap_locked", bus.locked, 1);

    // 6: reset mid-frame, then misaligned sync during confirm
    p0 = pulses;
    send_range(16'h7E81, 16'h0001, 0, 8);
    check("pre_rst_slot", bus.slot, 9);
    #1 rst_n = 1'b0;
    #1;
    check("arst_locked", bus.locked, 0);
    check("arst_slot", bus.slot, 0);
    check("arst_dout", bus.dout, 0);
    check("arst_valid", bus.dout_valid, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle();
    check("no_pulse_rst", pulses - p0, 0);
    send_range(16'hC001, 16'h0001, 0, 15);
    send_range(16'hC001, 16'h0081, 0, 7);
    check("realign_slot", bus.slot, 1);
    send_range(16'hC001, 16'h0000, 1, 15);
    check("realign_locked", bus.locked, 0);
    send_range(16'hC001, 16'h0001, 0, 15);
    check("restart_cnt", bus.locked, 0);
    send_range(16'hC001, 16'h0001, 0, 0);
    check("relock2", bus.locked, 1);
    send_range(16'hC001, 16'h0001, 1, 15);
    check("relock2_dout", bus.dout, 16'hC001);
    idle();
    check("relock2_pulses", pulses - p0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
